// File: rtl/int_ctrl.sv
// int_ctrl: single-level interrupt controller ahead of the CPU's PC register,
// PC-source mux and return-address stack.
//
// Captures rising edges on irq lines through a 2-flop synchroniser plus an
// edge flop, masks and prioritises them (lowest index wins), then sequences
// IDLE -> ENTER -> SERVICE -> EXIT. ENTER forces the PC to the line's vector
// and pushes the return address; RETI in SERVICE pops it and releases the
// controller. No nesting.
//
// Optional feature macro: INTC_ZSAVE_EN
//   defined   : zero flag saved in ENTER and restored (z_load/z_restore) in EXIT
//   undefined : no save flop, z_load and z_restore tied low
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   irq               asynchronous request lines, rising edge is the event
//   ie_set, ie_clr    EI / DI decoded (ie_clr wins when both asserted)
//   mask_we, mask_wd  mask register write strobe / data (1 = line enabled)
//   reti              RETI decoded, one cycle
//   pc_next           sequential next PC, pushed as return address
//   z_in              current zero flag
//   take_int          selects vec_addr on the PC-source mux (ENTER)
//   vec_addr          vector of the accepted line
//   push, push_data   stack push strobe and return address (ENTER)
//   pop               stack pop strobe (EXIT)
//   z_restore, z_load saved zero flag and its load strobe (EXIT)
//   pending           pending flags
//   in_service        high while a handler runs
//   gie               global interrupt enable
module int_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [9:0]  VEC_BASE   = 10'h3C0,
  parameter logic [9:0]  VEC_STRIDE = 10'h010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie_set,
  input  logic               ie_clr,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wd,
  input  logic               reti,
  input  logic [9:0]         pc_next,
  input  logic               z_in,
  output logic               take_int,
  output logic [9:0]         vec_addr,
  output logic               push,
  output logic [9:0]         push_data,
  output logic               pop,
  output logic               z_restore,
  output logic               z_load,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic               gie
);

  localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] s1, s2, s3, arm;
  logic               primed;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] mask_q, pend_q, eligible, clr_vec;
  logic [ID_W-1:0]    sel_id, cur_id;
  logic               found;
  logic               gie_q;

  // A line must be observed low after reset before a rising edge counts, so a
  // level held high through reset is not taken as a fresh event. primed marks
  // that s1 holds a real sample rather than its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      s3     <= '0;
      arm    <= '0;
      primed <= 1'b0;
    end else begin
      s1     <= irq;
      s2     <= s1;
      s3     <= s2;
      primed <= 1'b1;
      arm    <= arm | ({NUM_IRQ{primed}} & ~s1);
    end
  end

  assign edge_det = s2 & ~s3 & arm;
  assign eligible = pend_q & mask_q;

  // Lowest set index of eligible wins.
  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && !found) begin
        sel_id = ID_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = (state == ENTER) && (cur_id == ID_W'(i));
    end
  end

`ifdef INTC_ZSAVE_EN
  logic z_sv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_sv <= 1'b0;
    end else if (state == ENTER) begin
      z_sv <= z_in;
    end
  end

  assign z_load    = (state == EXIT);
  assign z_restore = (state == EXIT) & z_sv;
`else
  logic unused_z;
  assign unused_z  = z_in;
  assign z_load    = 1'b0;
  assign z_restore = 1'b0;
`endif

  // The accepted id is latched on the IDLE->ENTER transition so the vector is
  // stable throughout ENTER; pending[id] is then cleared as ENTER completes,
  // with a coincident new edge taking precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gie_q  <= 1'b0;
      mask_q <= '0;
      pend_q <= '0;
      cur_id <= '0;
    end else begin
      if (mask_we) mask_q <= mask_wd;
      pend_q <= (pend_q & ~clr_vec) | edge_det;
      case (state)
        IDLE: begin
          if (ie_clr)      gie_q <= 1'b0;
          else if (ie_set) gie_q <= 1'b1;
          if (gie_q && (|eligible)) begin
            cur_id <= sel_id;
            state  <= ENTER;
          end
        end
        ENTER: begin
          gie_q <= 1'b0;
          state <= SERVICE;
        end
        SERVICE: begin
          if (ie_clr)      gie_q <= 1'b0;
          else if (ie_set) gie_q <= 1'b1;
          if (reti) state <= EXIT;
        end
        EXIT: begin
          gie_q <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign take_int   = (state == ENTER);
  assign push       = (state == ENTER);
  assign push_data  = (state == ENTER) ? pc_next : '0;
  assign pop        = (state == EXIT);
  assign in_service = (state == SERVICE);
  assign vec_addr   = VEC_BASE + 10'(cur_id) * VEC_STRIDE;
  assign pending    = pend_q;
  assign gie        = gie_q;

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

`ifdef INTC_ZSAVE_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       ie_set, ie_clr, mask_we, reti, z_in;
  logic [3:0] mask_wd;
  logic [9:0] pc_next;
  logic       take_int, push, pop, z_restore, z_load, in_service, gie;
  logic [9:0] vec_addr, push_data;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_exit;
    logic [9:0] vec;
    logic [9:0] pd;
    logic       zr;
    logic       zl;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  int_ctrl #(
    .NUM_IRQ   (4),
    .VEC_BASE  (10'h3C0),
    .VEC_STRIDE(10'h010)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .ie_set    (ie_set),
    .ie_clr    (ie_clr),
    .mask_we   (mask_we),
    .mask_wd   (mask_wd),
    .reti      (reti),
    .pc_next   (pc_next),
    .z_in      (z_in),
    .take_int  (take_int),
    .vec_addr  (vec_addr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .z_restore (z_restore),
    .z_load    (z_load),
    .pending   (pending),
    .in_service(in_service),
    .gie       (gie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_entry(input logic [9:0] vec, input logic [9:0] pd);
    exp_t x;
    x.is_exit = 1'b0;
    x.vec     = vec;
    x.pd      = pd;
    x.zr      = 1'b0;
    x.zl      = 1'b0;
    sbq.push_back(x);
  endtask

  task automatic exp_exit(input logic z);
    exp_t x;
    x.is_exit = 1'b1;
    x.vec     = '0;
    x.pd      = '0;
    x.zr      = ZS ? z : 1'b0;
    x.zl      = ZS;
    sbq.push_back(x);
  endtask

  // Monitor: whenever the DUT presents a stack/PC strobe, pop and compare.
  always @(negedge clk) begin
    if (!reset && (take_int || push || pop || z_load)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event", {28'd0, take_int, push, pop, z_load}, 32'd0);
      end else begin
        e = sbq.pop_front();
        if (!e.is_exit) begin
          chk("enter_take_int", take_int, 1);
          chk("enter_push", push, 1);
          chk("enter_pop", pop, 0);
          chk("enter_vec_addr", vec_addr, e.vec);
          chk("enter_push_data", push_data, e.pd);
        end else begin
          chk("exit_pop", pop, 1);
          chk("exit_take_int", take_int, 0);
          chk("exit_z_load", z_load, e.zl);
          chk("exit_z_restore", z_restore, e.zr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; irq = '0; ie_set = 0; ie_clr = 0; mask_we = 0; mask_wd = '0;
    reti = 0; pc_next = '0; z_in = 0;
    tick(2);
    chk("rst_take_int", take_int, 0);
    chk("rst_push", push, 0);
    chk("rst_pop", pop, 0);
    chk("rst_z_load", z_load, 0);
    chk("rst_vec_addr", vec_addr, 10'h3C0);
    chk("rst_push_data", push_data, 0);
    chk("rst_z_restore", z_restore, 0);
    chk("rst_in_service", in_service, 0);
    chk("rst_gie", gie, 0);
    chk("rst_pending", pending, 0);
    reset = 1'b0;
    tick(2);

    // Basic entry on line 0
    mask_we = 1; mask_wd = 4'b0001; ie_set = 1;
    tick(1);
    mask_we = 0; ie_set = 0;
    chk("setup_gie", gie, 1);
    pc_next = 10'h025; z_in = 1;
    exp_entry(10'h3C0, 10'h025);
    irq[0] = 1;
    tick(3);
    chk("basic_pending_k2", pending, 4'b0001);
    chk("basic_no_take_k2", take_int, 0);
    tick(1);
    chk("basic_take_k3", take_int, 1);
    chk("basic_vec_k3", vec_addr, 10'h3C0);
    tick(1);
    chk("basic_in_service", in_service, 1);
    chk("basic_pending_cleared", pending, 0);
    chk("basic_gie_cleared", gie, 0);
    z_in = 0; irq[0] = 0;
    tick(3);
    chk("basic_waiting", in_service, 1);
    exp_exit(1'b1);
    reti = 1;
    tick(1);
    reti = 0;
    chk("basic_pop", pop, 1);
    tick(1);
    chk("basic_pop_one_cycle", pop, 0);
    chk("basic_gie_after_exit", gie, 1);
    chk("basic_released", in_service, 0);

    // Priority: lines 1 and 2 together, then set-wins on line 2
    mask_we = 1; mask_wd = 4'b1111;
    tick(1);
    mask_we = 0;
    pc_next = 10'h100; z_in = 0;
    exp_entry(10'h3D0, 10'h100);
    irq = 4'b0110;
    tick(4);
    chk("prio_take", take_int, 1);
    chk("prio_vec_id1", vec_addr, 10'h3D0);
    tick(1);
    chk("prio_pending_id2_left", pending, 4'b0100);
    z_in = 1; irq = '0;
    tick(4);
    exp_exit(1'b0);
    pc_next = 10'h200;
    exp_entry(10'h3E0, 10'h200);
    reti = 1;
    tick(1);
    reti = 0; irq[2] = 1;
    chk("prio_exit_pop", pop, 1);
    tick(1);
    chk("prio_idle_gap", take_int, 0);
    chk("prio_gie_idle", gie, 1);
    tick(1);
    chk("prio_take_id2", take_int, 1);
    chk("prio_vec_id2", vec_addr, 10'h3E0);
    tick(1);
    chk("setwins_pending", pending, 4'b0100);
    z_in = 0;
    exp_exit(1'b1);
    pc_next = 10'h201;
    exp_entry(10'h3E0, 10'h201);
    reti = 1;
    tick(1);
    reti = 0;
    tick(2);
    chk("setwins_reentry", take_int, 1);
    tick(1);
    chk("setwins_pending_clear", pending, 0);
    z_in = 1;
    tick(3);
    chk("held_line_single_event", pending, 0);
    exp_exit(1'b0);
    reti = 1;
    tick(1);
    reti = 0;
    tick(1);
    chk("prio_gie_final", gie, 1);
    irq[2] = 0;

    // Masking and global enable
    mask_we = 1; mask_wd = 4'b0111;
    tick(1);
    mask_we = 0;
    irq[3] = 1;
    tick(6);
    chk("mask_pending3", pending, 4'b1000);
    chk("mask_no_entry", take_int, 0);
    chk("mask_idle", in_service, 0);
    pc_next = 10'h050; z_in = 1;
    exp_entry(10'h3F0, 10'h050);
    mask_we = 1; mask_wd = 4'b1000;
    tick(1);
    mask_we = 0;
    chk("mask_take_not_yet", take_int, 0);
    tick(1);
    chk("mask_take", take_int, 1);
    chk("mask_vec_id3", vec_addr, 10'h3F0);
    tick(1);
    chk("mask_gie_in_handler", gie, 0);
    ie_set = 1;
    tick(1);
    ie_set = 0;
    chk("svc_ie_set_honoured", gie, 1);
    chk("svc_no_entry", in_service, 1);
    ie_set = 1; ie_clr = 1;
    tick(1);
    ie_set = 0; ie_clr = 0;
    chk("ie_clr_wins", gie, 0);
    z_in = 0;
    exp_exit(1'b1);
    reti = 1;
    tick(1);
    reti = 0;
    tick(1);
    chk("mask_gie_after_exit", gie, 1);
    irq[3] = 0;

    // RETI in IDLE is ignored
    reti = 1;
    tick(1);
    reti = 0;
    chk("reti_idle_pop", pop, 0);
    chk("reti_idle_state", in_service, 0);
    tick(1);
    chk("reti_idle_pop_late", pop, 0);

    // RETI in ENTER ignored, then reset mid-handler
    mask_we = 1; mask_wd = 4'b0011;
    tick(1);
    mask_we = 0;
    pc_next = 10'h077; z_in = 1;
    exp_entry(10'h3C0, 10'h077);
    irq[0] = 1;
    tick(4);
    chk("enter2_take", take_int, 1);
    reti = 1;
    tick(1);
    reti = 0;
    chk("reti_enter_pop", pop, 0);
    chk("reti_enter_service", in_service, 1);
    tick(2);
    chk("reti_enter_still_service", in_service, 1);
    ie_set = 1;
    tick(1);
    ie_set = 0;
    chk("rst_pre_gie", gie, 1);
    irq[1] = 1;
    tick(3);
    chk("rst_pre_pending", pending, 4'b0010);
    chk("rst_pre_service", in_service, 1);
    irq[1] = 0;
    reset = 1;
    #1;
    chk("midrst_in_service", in_service, 0);
    chk("midrst_gie", gie, 0);
    chk("midrst_pending", pending, 0);
    chk("midrst_pop", pop, 0);
    tick(2);
    reset = 0;
    mask_we = 1; mask_wd = 4'b0001; ie_set = 1;
    tick(1);
    mask_we = 0; ie_set = 0;
    tick(6);
    chk("held_through_reset_no_event", pending, 0);
    chk("held_through_reset_no_take", take_int, 0);
    irq[0] = 0;
    tick(4);
    exp_entry(10'h3C0, 10'h077);
    irq[0] = 1;
    tick(4);
    chk("rearm_take", take_int, 1);
    tick(1);
    chk("rearm_service", in_service, 1);
    exp_exit(1'b1);
    reti = 1;
    tick(1);
    reti = 0;
    tick(2);

    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
